// File: rtl/lsu_req_ctrl_if.sv
// Bundle between the execute stage, lsu_req_ctrl and the single-port DataMem:
// request handshake, response handshake and the DataMem control/data lines.
interface lsu_req_ctrl_if #(
  parameter int MEM_DEPTH = 4
);
  localparam int AW = $clog2(MEM_DEPTH) + 2;

  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [2:0]    req_funct3;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;

  logic          resp_valid;
  logic          resp_ready;
  logic          resp_is_load;
  logic          resp_err;
  logic [31:0]   resp_rdata;

  logic [AW-1:0] mem_rd_addr;
  logic [AW-1:0] mem_wr_addr;
  logic [31:0]   mem_wr_din;
  logic          mem_we;
  logic [2:0]    mem_strb;
  logic [31:0]   mem_rd_dout;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready,
    output resp_valid, resp_is_load, resp_err, resp_rdata,
    input  resp_ready,
    output mem_rd_addr, mem_wr_addr, mem_wr_din, mem_we, mem_strb,
    input  mem_rd_dout
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready,
    input  resp_valid, resp_is_load, resp_err, resp_rdata,
    output resp_ready,
    input  mem_rd_addr, mem_wr_addr, mem_wr_din, mem_we, mem_strb,
    output mem_rd_dout
  );
endinterface

// File: rtl/lsu_req_ctrl.sv
// LSU front-end: in-order request FIFO, legality check on the head entry,
// serialised DataMem access and a single-entry in-order response register.
module lsu_req_ctrl #(
  parameter int MEM_DEPTH = 4,
  parameter int Q_DEPTH   = 2
)(
  input  logic          clk,
  input  logic          rst,
  lsu_req_ctrl_if.slave bus
);
  localparam int AW = $clog2(MEM_DEPTH) + 2;
  localparam int PW = (Q_DEPTH > 1) ? $clog2(Q_DEPTH) : 1;

  typedef struct packed {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef enum logic {IDLE = 1'b0, LOAD_WAIT = 1'b1} state_t;

  // ---------------- request FIFO ----------------
  req_t          fifo_q [Q_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic          full, empty, push, pop;
  req_t          head;

  assign full          = (cnt_q == (PW+1)'(Q_DEPTH));
  assign empty         = (cnt_q == '0);
  // Gated on full only: a same-cycle pop never opens a slot for the push.
  assign push          = bus.req_valid & ~full;
  assign head          = fifo_q[rd_ptr_q];
  assign bus.req_ready = ~full;

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= {bus.req_we, bus.req_funct3, bus.req_addr, bus.req_wdata};
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + (PW+1)'(1);
      2'b01:   cnt_d = cnt_q - (PW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // ---------------- legality check on head ----------------
  logic bad_f3, uns_st, mis_h, mis_w, oor, err;

  assign bad_f3 = (head.f3 == 3'b011) | (head.f3 == 3'b110) | (head.f3 == 3'b111);
  assign uns_st = head.we & ((head.f3 == 3'b100) | (head.f3 == 3'b110));
  assign mis_h  = ((head.f3 == 3'b001) | (head.f3 == 3'b101)) & head.addr[0];
  assign mis_w  = (head.f3 == 3'b010) & (head.addr[1:0] != 2'b00);
  assign oor    = |head.addr[31:AW];
  assign err    = bad_f3 | uns_st | mis_h | mis_w | oor;

  // ---------------- control FSM ----------------
  state_t        state_q, state_d;
  logic          resp_valid_q, resp_err_q, resp_ld_q;
  logic [31:0]   resp_rdata_q;
  logic          rsp_load, rsp_err_d, rsp_ld_d;
  logic [31:0]   rsp_rdata_d;
  logic          slot_free;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [31:0]   wr_din;
  logic          we;
  logic [2:0]    strb;

  assign slot_free = ~resp_valid_q | bus.resp_ready;

  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    rsp_load    = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_ld_d    = 1'b0;
    rsp_rdata_d = '0;
    rd_addr     = '0;
    wr_addr     = '0;
    wr_din      = '0;
    we          = 1'b0;
    strb        = '0;
    case (state_q)
      IDLE: begin
        if (!empty && slot_free) begin
          if (err) begin
            pop       = 1'b1;
            rsp_load  = 1'b1;
            rsp_err_d = 1'b1;
            rsp_ld_d  = ~head.we;
          end else if (head.we) begin
            wr_addr  = head.addr[AW-1:0];
            wr_din   = head.wdata;
            strb     = head.f3;
            we       = 1'b1;
            pop      = 1'b1;
            rsp_load = 1'b1;
          end else begin
            rd_addr = head.addr[AW-1:0];
            strb    = head.f3;
            state_d = LOAD_WAIT;
          end
        end
      end
      LOAD_WAIT: begin
        // Slot is guaranteed free here: nothing loads it while the read is in flight.
        rd_addr     = head.addr[AW-1:0];
        strb        = head.f3;
        pop         = 1'b1;
        rsp_load    = 1'b1;
        rsp_ld_d    = 1'b1;
        rsp_rdata_d = bus.mem_rd_dout;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // ---------------- response register ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_ld_q    <= 1'b0;
      resp_rdata_q <= '0;
    end else if (rsp_load) begin
      resp_valid_q <= 1'b1;
      resp_err_q   <= rsp_err_d;
      resp_ld_q    <= rsp_ld_d;
      resp_rdata_q <= rsp_rdata_d;
    end else if (resp_valid_q && bus.resp_ready) begin
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_ld_q    <= 1'b0;
      resp_rdata_q <= '0;
    end
  end

  assign bus.resp_valid   = resp_valid_q;
  assign bus.resp_err     = resp_err_q;
  assign bus.resp_is_load = resp_ld_q;
  assign bus.resp_rdata   = resp_rdata_q;

  assign bus.mem_rd_addr  = rd_addr;
  assign bus.mem_wr_addr  = wr_addr;
  assign bus.mem_wr_din   = wr_din;
  assign bus.mem_we       = we;
  assign bus.mem_strb     = strb;
endmodule
